// File: rtl/audio_echo_stage.sv
// Stereo echo stage: mixes each ADC frame with an attenuated delayed frame
// from a circular buffer and stores the mixed result as feedback.
module audio_echo_stage #(
   parameter int ADDR_W     = 12,
   parameter int GAIN_SHIFT = 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              sample_valid,
   input  logic [31:0]       adc_data,
   input  logic              enable,
   input  logic [ADDR_W-1:0] delay_len,
   output logic [15:0]       ldata,
   output logic [15:0]       rdata,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {CLEAR, IDLE, READ, MIX} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] raddr;
   logic [31:0]       x;
   logic [31:0]       tap;
   logic [31:0]       mix_y;
   logic [31:0]       wdata;
   logic              byp;
   logic              accept;
   logic              drop;
   logic              we;
   logic [31:0]       mem [DEPTH];

   function automatic logic [15:0] sat_mix(input logic [15:0] xs,
                                           input logic [15:0] ds);
      logic signed [16:0] s;
      s = $signed({xs[15], xs}) + ($signed({ds[15], ds}) >>> GAIN_SHIFT);
      if (s > 17'sd32767)
         return 16'h7FFF;
      else if (s < -17'sd32768)
         return 16'h8000;
      return s[15:0];
   endfunction

   assign raddr = wr_ptr - delay_len;
   assign busy  = (state == CLEAR);
   assign mix_y = byp ? x : {sat_mix(x[31:16], tap[31:16]),
                             sat_mix(x[15:0], tap[15:0])};

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      drop      = 1'b0;
      we        = 1'b0;
      wdata     = 32'h0;
      unique case (state)
         CLEAR: begin
            we = 1'b1;
            if (wr_ptr == ADDR_W'(DEPTH-1))
               state_nxt = IDLE;
         end
         IDLE: begin
            if (sample_valid) begin
               accept    = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            drop      = sample_valid;
            state_nxt = MIX;
         end
         MIX: begin
            drop      = sample_valid;
            we        = 1'b1;
            wdata     = mix_y;
            state_nxt = IDLE;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state     <= CLEAR;
         wr_ptr    <= '0;
         ldata     <= 16'h0;
         rdata     <= 16'h0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         x         <= 32'h0;
         byp       <= 1'b1;
      end else begin
         state     <= state_nxt;
         out_valid <= 1'b0;
         if (we)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (accept) begin
            x   <= adc_data;
            byp <= !enable || (delay_len == '0);
         end
         if (drop)
            overrun <= 1'b1;
         if (state == MIX) begin
            ldata     <= mix_y[31:16];
            rdata     <= mix_y[15:0];
            out_valid <= 1'b1;
         end
      end
   end

   // Buffer write is suppressed under reset so an aborted frame leaves no trace.
   always_ff @(posedge clk) begin
      if (we && Reset)
         mem[wr_ptr] <= wdata;
      if (accept)
         tap <= mem[raddr];
   end

endmodule
